// File: rtl/txd_bps_clk_if.sv
// Handshake bundle between the UART TX controller and the baud tick generator.
// The controller (master) issues tx_start/tx_done; the tick generator (slave)
// returns the one-cycle bps_clk strobe consumed by the TX shift register.
interface txd_bps_clk_if;
  logic tx_start;
  logic tx_done;
  logic bps_clk;

  modport master (
    output tx_start,
    output tx_done,
    input  bps_clk
  );

  modport slave (
    input  tx_start,
    input  tx_done,
    output bps_clk
  );
endinterface

// File: rtl/txd_bps_clk.sv
// UART transmit-side baud-rate tick generator.
// Divides clk by BPS_CNT and emits a registered one-cycle bps_clk strobe while
// a frame is running. tx_start (re)starts bit timing, tx_done stops it; start
// wins when both arrive together so back-to-back frames need no idle cycle.
module txd_bps_clk #(
  parameter int unsigned CLK_FRE   = 50_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic               clk,
  input  logic               rst_n,
  txd_bps_clk_if.slave       bus
);

  localparam int unsigned BPS_CNT = CLK_FRE / BAUD_RATE;
  localparam int unsigned CW      = $clog2(BPS_CNT);
  // Keep a legal vector width even for a rejected BPS_CNT so elaboration
  // reaches the parameter check below instead of failing on a zero-width range.
  localparam int unsigned CntW    = (CW < 1) ? 1 : CW;

  localparam logic [CntW-1:0] CntMax = CntW'(BPS_CNT - 1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  // A divider of 1 would hold bps_clk high permanently; reject it.
  if (BPS_CNT < 2) begin : g_bps_cnt_check
    $error("txd_bps_clk: CLK_FRE / BAUD_RATE must be at least 2");
  end

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bps_q, bps_d;

  // Next-state and strobe decode; start has priority over done.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    bps_d   = 1'b0;
    if (bus.tx_start) begin
      // Held start keeps the counter parked at zero, so the first pulse
      // comes one cycle after start is released.
      state_d = StRun;
    end else if (bus.tx_done) begin
      // Cuts any pulse in flight; done while idle is harmless.
      state_d = StIdle;
    end else if (state_q == StRun) begin
      cnt_d = (cnt_q == CntMax) ? '0 : cnt_q + CntOne;
      bps_d = (cnt_q == '0);
    end
  end

  // State, counter and registered strobe; reset drops everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bps_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bps_q   <= bps_d;
    end
  end

  assign bus.bps_clk = bps_q;

  // The strobe is one cycle wide because the counter always leaves zero.
  a_bps_single_cycle : assert property (
    @(posedge clk) disable iff (!rst_n) bps_q |=> !bps_q
  );

  // Counter stays inside its modulo range.
  a_cnt_in_range : assert property (
    @(posedge clk) disable iff (!rst_n) cnt_q <= CntMax
  );

  // Idle means counter and strobe both parked at zero.
  a_idle_quiet : assert property (
    @(posedge clk) disable iff (!rst_n) (state_q == StIdle) |-> (cnt_q == '0 && !bps_q)
  );

endmodule

// File: tb/tb_txd_bps_clk.sv
// Bench for txd_bps_clk: a default-parameter instance (BPS_CNT=5208) and a
// small instance (BPS_CNT=4). A reference model predicts the edge numbers on
// which bps_clk must be high; a negedge monitor pops and compares every cycle.
module tb_txd_bps_clk;

  logic clk;
  logic rst_n;

  txd_bps_clk_if bus_d ();
  txd_bps_clk_if bus_s ();

  txd_bps_clk #(.CLK_FRE(50_000_000), .BAUD_RATE(9600)) dut_d (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_d)
  );

  txd_bps_clk #(.CLK_FRE(16), .BAUD_RATE(4)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;  // number of rising edges seen so far

  // Model state per instance: 0 = default, 1 = small.
  longint per [2] = '{5208, 4};
  bit     run_m [2];
  longint e_m   [2];
  longint exp_q [2][$];
  longint seen  [2][$];

  // Clock: 20 ns period, first rising edge at 20 ns.
  initial begin
    clk = 1'b0;
    #20;
    forever begin
      clk = 1'b1;
      #10;
      clk = 1'b0;
      #10;
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run_m[i] = 1'b0;
      exp_q[i].delete();
    end
  endtask

  // Pulses fall on edges E+1+k*P after the last start edge E.
  task automatic model_step(input int id, input logic st, input logic dn);
    if (st) begin
      run_m[id] = 1'b1;
      e_m[id]   = cyc;
    end else if (dn) begin
      run_m[id] = 1'b0;
    end else if (run_m[id] && ((cyc - e_m[id] - 1) % per[id] == 0)) begin
      exp_q[id].push_back(cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) model_reset();
    else begin
      model_step(0, bus_d.tx_start, bus_d.tx_done);
      model_step(1, bus_s.tx_start, bus_s.tx_done);
    end
  end

  always @(negedge rst_n) model_reset();

  task automatic check_out(input int id, input logic act);
    bit ex;
    ex = 1'b0;
    while (exp_q[id].size() > 0 && exp_q[id][0] < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_pulse dut=%0d edge=%0d got=0 want=1", id, exp_q[id][0]);
      void'(exp_q[id].pop_front());
    end
    if (exp_q[id].size() > 0 && exp_q[id][0] == cyc) begin
      ex = 1'b1;
      void'(exp_q[id].pop_front());
    end
    checks++;
    if (act !== ex) begin
      failures++;
      $display("FAIL bps_clk dut=%0d edge=%0d got=%b want=%b", id, cyc, act, ex);
    end
    if (act === 1'b1) seen[id].push_back(cyc);
  endtask

  // Monitor: compares both strobes against the scoreboard each cycle.
  always @(negedge clk) begin
    check_out(0, bus_d.bps_clk);
    check_out(1, bus_s.bps_clk);
  end

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic set_in(input int id, input logic st, input logic dn);
    if (id == 0) begin
      bus_d.tx_start = st;
      bus_d.tx_done  = dn;
    end else begin
      bus_s.tx_start = st;
      bus_s.tx_done  = dn;
    end
  endtask

  // One-cycle start (optionally with done); e returns the sampling edge.
  task automatic start_pulse(input int id, input logic with_done, output longint e);
    @(negedge clk);
    set_in(id, 1'b1, with_done);
    @(negedge clk);
    e = cyc;
    set_in(id, 1'b0, 1'b0);
    #1;
    seen[id].delete();
  endtask

  task automatic done_pulse(input int id);
    @(negedge clk);
    set_in(id, 1'b0, 1'b1);
    @(negedge clk);
    set_in(id, 1'b0, 1'b0);
    #1;
    seen[id].delete();
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Expect exactly n pulses at e+1, e+1+P, ... in the small instance.
  task automatic check_train(input string name, input longint e, input int n);
    check({name, "_count"}, seen[1].size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < seen[1].size()) check({name, "_edge"}, seen[1][k], e + 1 + 4 * k);
      else check({name, "_edge"}, -1, e + 1 + 4 * k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint e;
    bit     found;
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0);
    set_in(1, 1'b0, 1'b0);
    #5;
    check("reset_bps_d", bus_d.bps_clk, 0);
    check("reset_bps_s", bus_s.bps_clk, 0);
    #10;
    rst_n = 1'b1;

    // Default instance: start driven 30-50 ns, sampled on the 40 ns edge.
    start_pulse(0, 1'b0, e);
    check("start_edge_d", e, 2);
    @(negedge clk);  // 70 ns, inside the 60-80 ns pulse
    check("latency_high_d", bus_d.bps_clk, 1);
    @(negedge clk);  // 90 ns
    check("latency_low_d", bus_d.bps_clk, 0);

    // Small instance idle: no pulses without a start.
    wait_cyc(1000);
    check("idle_s_pulses", seen[1].size(), 0);

    // Period: pulses at E+1, E+5, E+9, E+13.
    start_pulse(1, 1'b0, e);
    wait_cyc(14);
    check_train("period", e, 4);

    // Stop: nothing after done, then restart gives first pulse at E+1.
    wait_cyc(2);
    done_pulse(1);
    wait_cyc(20);
    check("stop_s_pulses", seen[1].size(), 0);
    start_pulse(1, 1'b0, e);
    wait_cyc(3);
    check_train("after_stop", e, 1);

    // Start and done together mid-count: start wins and restarts timing.
    wait_cyc(3);
    start_pulse(1, 1'b1, e);
    wait_cyc(6);
    check_train("start_done", e, 2);

    // Start alone mid-count restarts timing the same way.
    wait_cyc(2);
    start_pulse(1, 1'b0, e);
    wait_cyc(6);
    check_train("restart", e, 2);

    // Random start/done traffic, including held and overlapping requests.
    repeat (3000) begin
      @(negedge clk);
      set_in(1, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    set_in(1, 1'b0, 1'b0);

    // Default instance spacing of 5208 cycles from its first pulse at edge 3.
    while (cyc < 10430) @(negedge clk);
    #1;
    check("default_count", seen[0].size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (k < seen[0].size()) check("default_edge", seen[0][k], 3 + 5208 * k);
      else check("default_edge", -1, 3 + 5208 * k);
    end
    done_pulse(0);
    wait_cyc(5300);
    check("default_stop_pulses", seen[0].size(), 0);

    // Asynchronous reset while the strobe is high.
    done_pulse(1);
    start_pulse(1, 1'b0, e);
    found = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus_s.bps_clk === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check("async_pulse_high", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_drop", bus_s.bps_clk, 0);
    seen[1].delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    wait_cyc(20);
    check("post_reset_idle", seen[1].size(), 0);
    start_pulse(1, 1'b0, e);
    wait_cyc(6);
    check_train("post_reset_start", e, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/txd_bps_clk.md
# txd_bps_clk

UART transmit-side baud-rate tick generator. Converts the system clock into a single-cycle `bps_clk` strobe at `BAUD_RATE`, gated by a run flag. The flag is set by `tx_start` and cleared by `tx_done`. It sits between the TX controller, which issues `tx_start`/`tx_done`, and the TX shift register, which advances one bit per `bps_clk`.

## Interface
Parameters:
- `CLK_FRE`, default 50_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: serial bit rate in baud.
- `BPS_CNT` (localparam) = `CLK_FRE / BAUD_RATE`, truncating integer division. This is 5208 for the defaults.
- `CW` (localparam) = `$clog2(BPS_CNT)`: counter width.

Ports:
- `clk` input 1: system clock, rising-edge.
- `rst_n` input 1: one clock domain; reset is asynchronous and active-low.
- `tx_done` input 1: frame finished, stops tick generation; sampled on `clk`.
- `tx_start` input 1: frame start, starts or restarts tick generation; sampled on `clk`.
- `bps_clk` output 1: registered one-cycle baud strobe.

## Operation
- Internal state:
  - `run` (1 bit).
  - `cnt` (`CW` bits, range 0..`BPS_CNT`-1).
  - `bps_clk` register.
- Reset (`rst_n`=0, asynchronous): `run`=0, `cnt`=0, `bps_clk`=0. All outputs are held low during reset.
- Edge priority, highest first:
  1. `tx_start`=1: `run`<=1, `cnt`<=0, `bps_clk`<=0. This applies whether idle or running; a start while running restarts bit timing.
  2. `tx_done`=1: `run`<=0, `cnt`<=0, `bps_clk`<=0.
  3. `run`=1:
     - `cnt` <= (`cnt`==`BPS_CNT`-1) ? 0 : `cnt`+1.
     - `bps_clk` <= (`cnt`==0).
  4. `run`=0: `cnt` and `bps_clk` hold 0.
- `tx_start` and `tx_done` high on the same edge: `tx_start` wins (run=1, counter cleared). This supports back-to-back frames.
- `tx_done` while idle: no effect.
- `tx_start` held high for several cycles: the counter is held at 0 and no pulse is produced until `tx_start` drops.
- Counter wrap is modulo `BPS_CNT` exactly. There is no fractional accumulation; the truncation error of `BPS_CNT` is accepted.
- Elaboration-time requirement: `BPS_CNT` >= 2. Flag the violation with a `$error` in an initial/generate check.

## Timing
- Let edge E be the edge at which `tx_start`=1 is sampled. Then:
  - `run`=1 after E.
  - The first `bps_clk` pulse is high for exactly one cycle, from edge E+1 to edge E+2. This is a 1-cycle latency.
  - Subsequent pulses occur every `BPS_CNT` cycles: rising at E+1+k·`BPS_CNT`.
- Let edge D be the edge at which `tx_done`=1 is sampled (without `tx_start`). Then:
  - `bps_clk` is 0 from D onward.
  - No further pulses occur until the next `tx_start`.
  - A pulse in flight at D is cut to end at D.
- `bps_clk` is never high for more than 1 consecutive cycle.
- Reset asserted mid-frame: `bps_clk` drops immediately (asynchronously) and `run` clears. After reset is released, the block stays idle until `tx_start`.
- With the defaults at 50 MHz (20 ns period), pulses are spaced 5208×20 ns = 104.16 µs.

## Test plan
- Reset and idle:
  - Stimulus: `rst_n`=0 for 15 ns, then 1; no start.
  - Required response: `bps_clk`=0 throughout 1000 cycles.
- Start latency (defaults, clk 20 ns period, first rising edge at 20 ns):
  - Stimulus: `tx_start` high from 30 to 50 ns, sampled at 40 ns.
  - Required response: `bps_clk`=1 exactly during 60–80 ns, 0 otherwise until 60 ns + 104160 ns.
- Period with small parameters (`CLK_FRE`=16, `BAUD_RATE`=4, so `BPS_CNT`=4):
  - Stimulus: pulse `tx_start` once.
  - Required response: `bps_clk` pulses on cycles E+1, E+5, E+9, E+13, each 1 cycle wide.
- Stop:
  - Stimulus: with `BPS_CNT`=4 running, assert `tx_done` for 1 cycle.
  - Required response: no pulse after the sampling edge, `cnt` returns to 0, and a later `tx_start` again yields its first pulse at E+1.
- Simultaneous start and done, plus restart:
  - Stimulus: `tx_start`=`tx_done`=1 on one edge mid-count.
  - Required response: `run` stays 1, `cnt` is cleared, next pulse at E+1.
  - Stimulus: `tx_start` alone mid-count.
  - Required response: same restart timing.
- Asynchronous reset during operation:
  - Stimulus: drop `rst_n` between clock edges while `bps_clk`=1.
  - Required response: `bps_clk` falls without waiting for a clock edge, and it remains 0 after release until a new `tx_start`.
